// File: rtl/apb_pad_ctrl_shadow.sv
// APB pad-control slave: per-pad mux/cfg/lock registers with a shadow bank
// and a commit sequencer that copies shadow->live a slice of pads per cycle.
module apb_pad_ctrl_shadow #(
   parameter int                APB_ADDR_WIDTH = 12,
   parameter int                N_IO           = 64,
   parameter int                MUX_W          = 2,
   parameter int                CFG_W          = 6,
   parameter int                PADS_PER_CYCLE = 8,
   parameter logic [CFG_W-1:0]  CFG_RST        = '1
) (
   input  logic                          HCLK,
   input  logic                          HRESET,
   input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
   input  logic [31:0]                   PWDATA,
   input  logic                          PWRITE,
   input  logic                          PSEL,
   input  logic                          PENABLE,
   output logic [31:0]                   PRDATA,
   output logic                          PREADY,
   output logic                          PSLVERR,
   output logic [N_IO-1:0][MUX_W-1:0]    pad_mux_o,
   output logic [N_IO-1:0][CFG_W-1:0]    pad_cfg_o,
   output logic [N_IO-1:0]               pad_lock_o,
   output logic                          busy_o
);

   localparam int IDX_W  = $clog2(N_IO + PADS_PER_CYCLE + 1);
   localparam int PIDX_W = (N_IO > 1) ? $clog2(N_IO) : 1;
   localparam logic [31:0] INFO_VAL = {16'(N_IO), 8'(MUX_W), 8'(CFG_W)};

   typedef enum logic [0:0] {S_IDLE, S_RESP} bus_state_e;

   // Handshake: a transfer is accepted in IDLE when PSEL&PENABLE are high and
   // it is not stalled; the following cycle (RESP) drives PREADY=1 with
   // PRDATA/PSLVERR valid, then the FSM returns to IDLE unconditionally.
   bus_state_e                 state_q, state_d;
   logic                       pready_q, pready_d;
   logic                       pslverr_q, pslverr_d;
   logic [31:0]                prdata_q, prdata_d;
   logic [N_IO-1:0][MUX_W-1:0] live_mux_q, live_mux_d;
   logic [N_IO-1:0][CFG_W-1:0] live_cfg_q, live_cfg_d;
   logic [N_IO-1:0][MUX_W-1:0] shadow_mux_q, shadow_mux_d;
   logic [N_IO-1:0][CFG_W-1:0] shadow_cfg_q, shadow_cfg_d;
   logic [N_IO-1:0]            lock_q, lock_d;
   logic                       shadow_en_q, shadow_en_d;
   logic                       busy_q, busy_d;
   logic [IDX_W-1:0]           idx_q, idx_d;

   logic [11:0]       addr;
   logic              is_info, is_ctrl, is_pad, pad_ok, stall;
   logic [7:0]        pad_idx;
   logic [PIDX_W-1:0] pad_sel;
   logic [IDX_W-1:0]  idx_end;
   logic [MUX_W-1:0]  wr_mux;
   logic [CFG_W-1:0]  wr_cfg;
   logic [31:0]       pad_rd;
   logic              unused_ok;

   assign addr    = PADDR[11:0];
   assign is_info = (addr[11:2] == 10'd0);
   assign is_ctrl = (addr[11:2] == 10'd1);
   assign is_pad  = (addr[11:10] == 2'b01);
   assign pad_idx = addr[9:2];
   assign pad_sel = pad_idx[PIDX_W-1:0];
   assign pad_ok  = ({1'b0, pad_idx} < 9'(N_IO));
   // PAD writes wait while the sequencer owns the live bank.
   assign stall   = PWRITE && is_pad && busy_q;
   assign idx_end = idx_q + IDX_W'(PADS_PER_CYCLE);
   assign wr_mux  = PWDATA[MUX_W-1:0];
   assign wr_cfg  = PWDATA[8 +: CFG_W];
   assign unused_ok = ^{PADDR, PWDATA};

   always_comb begin
      pad_rd = '0;
      if (shadow_en_q) begin
         pad_rd[MUX_W-1:0]  = shadow_mux_q[pad_sel];
         pad_rd[8 +: CFG_W] = shadow_cfg_q[pad_sel];
      end else begin
         pad_rd[MUX_W-1:0]  = live_mux_q[pad_sel];
         pad_rd[8 +: CFG_W] = live_cfg_q[pad_sel];
      end
      pad_rd[31] = lock_q[pad_sel];
   end

   always_comb begin
      state_d      = state_q;
      pready_d     = 1'b0;
      pslverr_d    = 1'b0;
      prdata_d     = '0;
      live_mux_d   = live_mux_q;
      live_cfg_d   = live_cfg_q;
      shadow_mux_d = shadow_mux_q;
      shadow_cfg_d = shadow_cfg_q;
      lock_d       = lock_q;
      shadow_en_d  = shadow_en_q;
      busy_d       = busy_q;
      idx_d        = idx_q;

      if (busy_q) begin
         for (int p = 0; p < N_IO; p++) begin
            if ((IDX_W'(p) >= idx_q) && (IDX_W'(p) < idx_end) && !lock_q[p]) begin
               live_mux_d[p] = shadow_mux_q[p];
               live_cfg_d[p] = shadow_cfg_q[p];
            end
         end
         idx_d = idx_end;
         if (idx_end >= IDX_W'(N_IO)) busy_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (PSEL && PENABLE && !stall) begin
               state_d  = S_RESP;
               pready_d = 1'b1;
               if (is_info) begin
                  if (!PWRITE) prdata_d = INFO_VAL;
               end else if (is_ctrl) begin
                  if (PWRITE) begin
                     shadow_en_d = PWDATA[0];
                     if (PWDATA[1] && PWDATA[0] && !busy_q) begin
                        busy_d = 1'b1;
                        idx_d  = '0;
                     end
                  end else begin
                     prdata_d = {29'd0, busy_q, 1'b0, shadow_en_q};
                  end
               end else if (is_pad && pad_ok) begin
                  if (PWRITE) begin
                     if (lock_q[pad_sel]) begin
                        pslverr_d = 1'b1;
                     end else begin
                        shadow_mux_d[pad_sel] = wr_mux;
                        shadow_cfg_d[pad_sel] = wr_cfg;
                        if (!shadow_en_q) begin
                           live_mux_d[pad_sel] = wr_mux;
                           live_cfg_d[pad_sel] = wr_cfg;
                        end
                        if (PWDATA[31]) lock_d[pad_sel] = 1'b1;
                     end
                  end else begin
                     prdata_d = pad_rd;
                  end
               end else begin
                  pslverr_d = 1'b1;
               end
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q      <= S_IDLE;
         pready_q     <= 1'b0;
         pslverr_q    <= 1'b0;
         prdata_q     <= '0;
         live_mux_q   <= '0;
         live_cfg_q   <= {N_IO{CFG_RST}};
         shadow_mux_q <= '0;
         shadow_cfg_q <= {N_IO{CFG_RST}};
         lock_q       <= '0;
         shadow_en_q  <= 1'b0;
         busy_q       <= 1'b0;
         idx_q        <= '0;
      end else begin
         state_q      <= state_d;
         pready_q     <= pready_d;
         pslverr_q    <= pslverr_d;
         prdata_q     <= prdata_d;
         live_mux_q   <= live_mux_d;
         live_cfg_q   <= live_cfg_d;
         shadow_mux_q <= shadow_mux_d;
         shadow_cfg_q <= shadow_cfg_d;
         lock_q       <= lock_d;
         shadow_en_q  <= shadow_en_d;
         busy_q       <= busy_d;
         idx_q        <= idx_d;
      end
   end

   assign PRDATA     = prdata_q;
   assign PREADY     = pready_q;
   assign PSLVERR    = pslverr_q;
   assign pad_mux_o  = live_mux_q;
   assign pad_cfg_o  = live_cfg_q;
   assign pad_lock_o = lock_q;
   assign busy_o     = busy_q;

endmodule
